// File: rtl/ofdm_sched_pkg.sv
// Shared encodings and limits for the OFDM symbol scheduler.
package ofdm_sched_pkg;
   localparam int unsigned MIN_LOG2_N = 3;
   localparam int unsigned MAX_LOG2_N = 13;

   typedef enum logic [1:0] {
      SEL_NULL  = 2'd0,
      SEL_PRE   = 2'd1,
      SEL_PILOT = 2'd2,
      SEL_DATA  = 2'd3
   } sel_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_e;
endpackage

// File: rtl/ofdm_symbol_scheduler_if.sv
// Upstream QAM handshake plus downstream slot stream between scheduler and mapper.
interface ofdm_symbol_scheduler_if #(
   parameter int unsigned IDX_W = 13,
   parameter int unsigned SYM_W = 16
) ();
   logic                 data_valid;
   logic                 data_ready;
   logic                 out_valid;
   logic                 out_ready;
   ofdm_sched_pkg::sel_e out_sel;
   logic [IDX_W-1:0]     out_idx;
   logic [SYM_W-1:0]     out_sym;
   logic                 out_last;
   logic                 out_frame_last;

   modport master (
      input  data_valid, out_ready,
      output data_ready, out_valid, out_sel, out_idx, out_sym, out_last, out_frame_last
   );

   modport slave (
      output data_valid, out_ready,
      input  data_ready, out_valid, out_sel, out_idx, out_sym, out_last, out_frame_last
   );
endinterface

// File: rtl/ofdm_pilot_tracker.sv
// Pilot down-counter: marks a non-DC bin as pilot when the count reaches zero.
module ofdm_pilot_tracker #(
   parameter int unsigned IDX_W = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [IDX_W-1:0] off,
   input  logic [IDX_W-1:0] spc,
   input  logic [IDX_W-1:0] idx,
   output logic             is_pilot
);
   logic [IDX_W-1:0] cnt_q;

   // Reload with spacing-1 whenever the count is consumed at zero (pilot or DC).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= off;
      end else if (step) begin
         cnt_q <= (cnt_q == '0) ? (spc - IDX_W'(1)) : (cnt_q - IDX_W'(1));
      end
   end

   assign is_pilot = (cnt_q == '0) && (spc != '0) && (idx != '0);
endmodule

// File: rtl/ofdm_symbol_scheduler.sv
// Sequences one OFDM frame (preamble then data with pilots), one subcarrier slot per handshake.
module ofdm_symbol_scheduler #(
   parameter int unsigned MAX_LOG2_N = 13,
   parameter int unsigned SYM_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_start,
   input  logic                  cfg_abort,
   input  logic [3:0]            cfg_log2n,
   input  logic [3:0]            cfg_num_pre,
   input  logic [SYM_W-1:0]      cfg_num_data,
   input  logic [MAX_LOG2_N-1:0] cfg_pilot_off,
   input  logic [MAX_LOG2_N-1:0] cfg_pilot_spc,
   ofdm_symbol_scheduler_if.master bus,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
);
   import ofdm_sched_pkg::*;

   localparam int unsigned IDX_W    = MAX_LOG2_N;
   localparam int unsigned NPTS_W   = IDX_W + 1;
   localparam logic [3:0]  LOG2N_LO = 4'(MIN_LOG2_N);
   localparam logic [3:0]  LOG2N_HI = 4'(MAX_LOG2_N);

   state_e           state_q, state_n;
   logic [IDX_W-1:0] idx_q, idx_n, off_q, off_n, spc_q, spc_n, pt_off;
   logic [SYM_W-1:0] sym_q, sym_n, num_data_q, num_data_n;
   logic [3:0]       log2n_q, log2n_n, num_pre_q, num_pre_n;
   logic [NPTS_W-1:0] n_pts;
   logic             busy_n, done_n, cfg_err_n, cfg_ok;
   logic             last, frame_last, hs, is_pilot, pt_load, pt_step;
   logic             out_valid, data_ready;
   sel_e             sel;

   assign cfg_ok     = (cfg_log2n >= LOG2N_LO) && (cfg_log2n <= LOG2N_HI) && (cfg_num_data != '0);
   assign n_pts      = NPTS_W'(1) << log2n_q;
   assign last       = (idx_q == IDX_W'(n_pts - NPTS_W'(1)));
   assign frame_last = last && (state_q == DATA) && (sym_q == num_data_q - SYM_W'(1));
   assign pt_off     = (state_q == IDLE) ? cfg_pilot_off : off_q;

   ofdm_pilot_tracker #(.IDX_W(IDX_W)) u_pilot (
      .clk      (clk),
      .rst      (rst),
      .load     (pt_load),
      .step     (pt_step),
      .off      (pt_off),
      .spc      (spc_q),
      .idx      (idx_q),
      .is_pilot (is_pilot)
   );

   // Slot classification and handshake qualifiers, all from registered state.
   always_comb begin
      sel        = SEL_NULL;
      out_valid  = 1'b0;
      data_ready = 1'b0;
      case (state_q)
         PRE: begin
            sel       = SEL_PRE;
            out_valid = 1'b1;
         end
         DATA: begin
            if (is_pilot)           sel = SEL_PILOT;
            else if (idx_q == '0)   sel = SEL_NULL;
            else                    sel = SEL_DATA;
            out_valid  = (sel == SEL_DATA) ? bus.data_valid : 1'b1;
            data_ready = (sel == SEL_DATA) && bus.out_ready;
         end
         default: ;
      endcase
   end

   assign hs = out_valid && bus.out_ready;

   // Next-state, index/symbol counters and configuration latch.
   always_comb begin
      state_n    = state_q;
      idx_n      = idx_q;
      sym_n      = sym_q;
      log2n_n    = log2n_q;
      num_pre_n  = num_pre_q;
      num_data_n = num_data_q;
      off_n      = off_q;
      spc_n      = spc_q;
      cfg_err_n  = cfg_err;
      pt_load    = 1'b0;
      pt_step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg_start && !cfg_abort) begin
               if (!cfg_ok) begin
                  cfg_err_n = 1'b1;
               end else begin
                  cfg_err_n  = 1'b0;
                  log2n_n    = cfg_log2n;
                  num_pre_n  = cfg_num_pre;
                  num_data_n = cfg_num_data;
                  off_n      = cfg_pilot_off;
                  spc_n      = cfg_pilot_spc;
                  idx_n      = '0;
                  sym_n      = '0;
                  state_n    = (cfg_num_pre != '0) ? PRE : DATA;
                  pt_load    = (cfg_num_pre == '0);
               end
            end
         end
         PRE: begin
            if (hs) begin
               if (last) begin
                  idx_n = '0;
                  if (sym_q == SYM_W'(num_pre_q - 4'd1)) begin
                     sym_n   = '0;
                     state_n = DATA;
                     pt_load = 1'b1;
                  end else begin
                     sym_n = sym_q + SYM_W'(1);
                  end
               end else begin
                  idx_n = idx_q + IDX_W'(1);
               end
            end
         end
         DATA: begin
            if (hs) begin
               if (last) begin
                  idx_n = '0;
                  if (frame_last) begin
                     sym_n   = '0;
                     state_n = DONE;
                  end else begin
                     sym_n   = sym_q + SYM_W'(1);
                     pt_load = 1'b1;
                  end
               end else begin
                  idx_n   = idx_q + IDX_W'(1);
                  pt_step = 1'b1;
               end
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (cfg_abort) begin
         state_n = IDLE;
         idx_n   = '0;
         sym_n   = '0;
      end
      busy_n = (state_n != IDLE);
      done_n = (state_n == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         sym_q      <= '0;
         log2n_q    <= '0;
         num_pre_q  <= '0;
         num_data_q <= '0;
         off_q      <= '0;
         spc_q      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         state_q    <= state_n;
         idx_q      <= idx_n;
         sym_q      <= sym_n;
         log2n_q    <= log2n_n;
         num_pre_q  <= num_pre_n;
         num_data_q <= num_data_n;
         off_q      <= off_n;
         spc_q      <= spc_n;
         busy       <= busy_n;
         done       <= done_n;
         cfg_err    <= cfg_err_n;
      end
   end

   assign bus.out_valid      = out_valid;
   assign bus.data_ready     = data_ready;
   assign bus.out_sel        = sel;
   assign bus.out_idx        = idx_q;
   assign bus.out_sym        = sym_q;
   assign bus.out_last       = last && ((state_q == PRE) || (state_q == DATA));
   assign bus.out_frame_last = frame_last;
endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Directed bench for ofdm_symbol_scheduler: frame sequencing, backpressure, abort, reset, config checks.
module tb_ofdm_symbol_scheduler;
   import ofdm_sched_pkg::*;

   localparam int unsigned IDX_W = 13;
   localparam int unsigned SYM_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_start, cfg_abort;
   logic [3:0]       cfg_log2n, cfg_num_pre;
   logic [SYM_W-1:0] cfg_num_data;
   logic [IDX_W-1:0] cfg_pilot_off, cfg_pilot_spc;
   logic             busy, done, cfg_err;
   int               checks, failures;

   ofdm_symbol_scheduler_if #(.IDX_W(IDX_W), .SYM_W(SYM_W)) bus ();

   ofdm_symbol_scheduler #(.MAX_LOG2_N(13), .SYM_W(SYM_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_start     (cfg_start),
      .cfg_abort     (cfg_abort),
      .cfg_log2n     (cfg_log2n),
      .cfg_num_pre   (cfg_num_pre),
      .cfg_num_data  (cfg_num_data),
      .cfg_pilot_off (cfg_pilot_off),
      .cfg_pilot_spc (cfg_pilot_spc),
      .bus           (bus),
      .busy          (busy),
      .done          (done),
      .cfg_err       (cfg_err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Data-symbol bin pattern for N=8, off=1, spc=3: DC, pilots at 1/4/7.
   function automatic sel_e exp_basic_sel(input int pos);
      case (pos)
         0:       return SEL_NULL;
         1, 4, 7: return SEL_PILOT;
         default: return SEL_DATA;
      endcase
   endfunction

   task automatic start_frame(input logic [3:0] l2, input logic [3:0] np, input logic [SYM_W-1:0] nd,
                              input logic [IDX_W-1:0] off, input logic [IDX_W-1:0] spc);
      @(negedge clk);
      cfg_log2n = l2; cfg_num_pre = np; cfg_num_data = nd;
      cfg_pilot_off = off; cfg_pilot_spc = spc;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({bus.out_valid, bus.data_ready, busy, done, cfg_err, bus.out_last, bus.out_frame_last} !== 7'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000000",
                  {bus.out_valid, bus.data_ready, busy, done, cfg_err, bus.out_last, bus.out_frame_last});
      end
      checks++;
      if ({bus.out_sel, bus.out_idx, bus.out_sym} !== '0) begin
         failures++;
         $display("FAIL reset_slot got sel=%0d idx=%0d sym=%0d exp all 0", bus.out_sel, bus.out_idx, bus.out_sym);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      int hs_n = 0, dr_n = 0, ei, esym;
      sel_e es;
      bus.out_ready = 1'b1; bus.data_valid = 1'b1;
      start_frame(4'd3, 4'd1, 16'd2, 13'd1, 13'd3);
      #1;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
      for (int cyc = 0; cyc < 100 && hs_n < 24; cyc++) begin
         if (cyc > 0) #1;
         if (bus.data_ready) dr_n++;
         if (bus.out_valid && bus.out_ready) begin
            if (hs_n < 8) begin es = SEL_PRE; ei = hs_n; esym = 0; end
            else begin es = exp_basic_sel((hs_n - 8) % 8); ei = (hs_n - 8) % 8; esym = (hs_n - 8) / 8; end
            checks++;
            if ({bus.out_sel, bus.out_idx, bus.out_sym, bus.out_last, bus.out_frame_last} !==
                {es, IDX_W'(ei), SYM_W'(esym), (ei == 7), (hs_n == 23)}) begin
               failures++;
               $display("FAIL basic_slot%0d got sel=%0d idx=%0d sym=%0d last=%b fl=%b exp sel=%0d idx=%0d sym=%0d last=%b fl=%b",
                        hs_n, bus.out_sel, bus.out_idx, bus.out_sym, bus.out_last, bus.out_frame_last,
                        es, ei, esym, (ei == 7), (hs_n == 23));
            end
            hs_n++;
         end
         @(negedge clk);
      end
      checks++;
      if (hs_n != 24) begin failures++; $display("FAIL basic_count got=%0d exp=24", hs_n); end
      checks++;
      if (dr_n != 8) begin failures++; $display("FAIL basic_data_ready got=%0d exp=8", dr_n); end
      #1;
      checks++;
      if ({done, busy, bus.out_valid} !== 3'b110) begin
         failures++; $display("FAIL basic_done got done/busy/valid=%b exp=110", {done, busy, bus.out_valid});
      end
      @(negedge clk); #1;
      checks++;
      if ({done, busy} !== 2'b00) begin failures++; $display("FAIL basic_idle got done/busy=%b exp=00", {done, busy}); end
   endtask

   task automatic test_backpressure();
      int hs_n = 0, dv_low = 0, ei, esym;
      bit dv_hit = 0, prev_stall = 0;
      logic [IDX_W+SYM_W+2:0] prev_slot = '0;
      sel_e es;
      bus.out_ready = 1'b1; bus.data_valid = 1'b1;
      start_frame(4'd3, 4'd1, 16'd2, 13'd1, 13'd3);
      for (int cyc = 0; cyc < 300 && hs_n < 24; cyc++) begin
         bus.out_ready = (cyc % 2 == 0);
         if (!dv_hit && bus.out_sel == SEL_DATA && bus.out_idx == 13'd2) begin dv_low = 5; dv_hit = 1; end
         bus.data_valid = (dv_low == 0);
         if (dv_low > 0) dv_low--;
         #1;
         if (prev_stall) begin
            checks++;
            if ({bus.out_sel, bus.out_idx, bus.out_sym, bus.out_last} !== prev_slot) begin
               failures++;
               $display("FAIL bp_hold cyc%0d got=%h exp=%h", cyc, {bus.out_sel, bus.out_idx, bus.out_sym, bus.out_last}, prev_slot);
            end
         end
         if (!bus.out_ready) begin
            checks++;
            if (bus.data_ready !== 1'b0) begin failures++; $display("FAIL bp_data_ready cyc%0d got=%b exp=0", cyc, bus.data_ready); end
         end
         if (!bus.data_valid && bus.out_sel == SEL_DATA) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_gate cyc%0d got=%b exp=0", cyc, bus.out_valid); end
         end
         if (bus.out_valid && bus.out_ready) begin
            if (hs_n < 8) begin es = SEL_PRE; ei = hs_n; esym = 0; end
            else begin es = exp_basic_sel((hs_n - 8) % 8); ei = (hs_n - 8) % 8; esym = (hs_n - 8) / 8; end
            checks++;
            if ({bus.out_sel, bus.out_idx, bus.out_sym, bus.out_frame_last} !== {es, IDX_W'(ei), SYM_W'(esym), (hs_n == 23)}) begin
               failures++;
               $display("FAIL bp_slot%0d got sel=%0d idx=%0d sym=%0d exp sel=%0d idx=%0d sym=%0d",
                        hs_n, bus.out_sel, bus.out_idx, bus.out_sym, es, ei, esym);
            end
            hs_n++;
         end
         prev_stall = !(bus.out_valid && bus.out_ready);
         prev_slot  = {bus.out_sel, bus.out_idx, bus.out_sym, bus.out_last};
         @(negedge clk);
      end
      checks++;
      if (hs_n != 24) begin failures++; $display("FAIL bp_count got=%0d exp=24", hs_n); end
      checks++;
      if (!dv_hit) begin failures++; $display("FAIL bp_dv_window got=0 exp=1"); end
      #1;
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", done); end
      bus.out_ready = 1'b1; bus.data_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_illegal();
      logic [3:0]       bad_l2 [3] = '{4'd2, 4'd14, 4'd3};
      logic [SYM_W-1:0] bad_nd [3] = '{16'd2, 16'd2, 16'd0};
      for (int i = 0; i < 3; i++) begin
         start_frame(bad_l2[i], 4'd1, bad_nd[i], 13'd1, 13'd3);
         #1;
         checks++;
         if ({cfg_err, busy, bus.out_valid} !== 3'b100) begin
            failures++; $display("FAIL illegal%0d got err/busy/valid=%b exp=100", i, {cfg_err, busy, bus.out_valid});
         end
      end
      start_frame(4'd3, 4'd0, 16'd1, 13'd1, 13'd3);
      #1;
      checks++;
      if ({cfg_err, busy} !== 2'b01) begin failures++; $display("FAIL illegal_clear got err/busy=%b exp=01", {cfg_err, busy}); end
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_abort = 1'b0;
      #1;
      checks++;
      if ({busy, bus.out_valid} !== 2'b00) begin failures++; $display("FAIL illegal_abort got busy/valid=%b exp=00", {busy, bus.out_valid}); end
   endtask

   task automatic test_abort();
      int seen = 0;
      bus.out_ready = 1'b1; bus.data_valid = 1'b1;
      start_frame(4'd3, 4'd1, 16'd2, 13'd1, 13'd3);
      repeat (12) @(negedge clk);
      #1;
      checks++;
      if ({bus.out_sel, bus.out_idx, bus.out_sym} !== {SEL_PILOT, 13'd4, 16'd0}) begin
         failures++; $display("FAIL abort_pos got sel=%0d idx=%0d sym=%0d exp sel=2 idx=4 sym=0", bus.out_sel, bus.out_idx, bus.out_sym);
      end
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_abort = 1'b0;
      #1;
      checks++;
      if ({busy, bus.out_valid, done} !== 3'b000) begin
         failures++; $display("FAIL abort_idle got busy/valid/done=%b exp=000", {busy, bus.out_valid, done});
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (done || bus.out_valid || busy) seen++;
      end
      checks++;
      if (seen != 0) begin failures++; $display("FAIL abort_quiet got=%0d active cycles exp=0", seen); end
      @(negedge clk);
      cfg_log2n = 4'd3; cfg_num_pre = 4'd1; cfg_num_data = 16'd1;
      cfg_start = 1'b1; cfg_abort = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0; cfg_abort = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL abort_priority got busy=%b exp=0", busy); end
   endtask

   task automatic test_midreset();
      bus.out_ready = 1'b1; bus.data_valid = 1'b1;
      start_frame(4'd3, 4'd1, 16'd2, 13'd1, 13'd3);
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if ({bus.out_sel, bus.out_idx} !== {SEL_PRE, 13'd5}) begin
         failures++; $display("FAIL midrst_pos got sel=%0d idx=%0d exp sel=1 idx=5", bus.out_sel, bus.out_idx);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.data_ready, busy, done, cfg_err, bus.out_last, bus.out_sel, bus.out_idx, bus.out_sym} !== '0) begin
         failures++;
         $display("FAIL midrst_outputs got valid=%b busy=%b sel=%0d idx=%0d sym=%0d exp all 0",
                  bus.out_valid, busy, bus.out_sel, bus.out_idx, bus.out_sym);
      end
      @(negedge clk);
      rst = 1'b1;
      start_frame(4'd3, 4'd1, 16'd2, 13'd1, 13'd3);
      #1;
      checks++;
      if ({busy, bus.out_sel, bus.out_idx, bus.out_sym} !== {1'b1, SEL_PRE, 13'd0, 16'd0}) begin
         failures++; $display("FAIL midrst_restart got busy=%b sel=%0d idx=%0d sym=%0d exp busy=1 sel=1 idx=0 sym=0",
                              busy, bus.out_sel, bus.out_idx, bus.out_sym);
      end
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_abort = 1'b0;
   endtask

   task automatic test_edge();
      int hs_n = 0;
      sel_e es;
      bus.out_ready = 1'b1; bus.data_valid = 1'b1;
      start_frame(4'd4, 4'd0, 16'd1, 13'd2, 13'd0);
      for (int cyc = 0; cyc < 100 && hs_n < 16; cyc++) begin
         cfg_start = (hs_n == 5);
         if (hs_n == 5) begin cfg_log2n = 4'd3; cfg_num_pre = 4'd2; cfg_pilot_spc = 13'd2; end
         #1;
         if (bus.out_valid && bus.out_ready) begin
            es = (hs_n == 0) ? SEL_NULL : SEL_DATA;
            checks++;
            if ({bus.out_sel, bus.out_idx, bus.out_sym, bus.out_last, bus.out_frame_last} !==
                {es, IDX_W'(hs_n), 16'd0, (hs_n == 15), (hs_n == 15)}) begin
               failures++;
               $display("FAIL edge_slot%0d got sel=%0d idx=%0d sym=%0d last=%b fl=%b exp sel=%0d idx=%0d sym=0 last=%b",
                        hs_n, bus.out_sel, bus.out_idx, bus.out_sym, bus.out_last, bus.out_frame_last, es, hs_n, (hs_n == 15));
            end
            hs_n++;
         end
         @(negedge clk);
      end
      cfg_start = 1'b0;
      checks++;
      if (hs_n != 16) begin failures++; $display("FAIL edge_count got=%0d exp=16", hs_n); end
      #1;
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL edge_done got=%b exp=1", done); end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({busy, done, bus.out_valid} !== 3'b000) begin
         failures++; $display("FAIL edge_no_restart got busy/done/valid=%b exp=000", {busy, done, bus.out_valid});
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
      cfg_log2n = '0; cfg_num_pre = '0; cfg_num_data = '0; cfg_pilot_off = '0; cfg_pilot_spc = '0;
      bus.out_ready = 1'b0; bus.data_valid = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_illegal();
      test_abort();
      test_midreset();
      test_edge();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
